// File: rtl/burst_seq_fsm.sv
// burst_seq_fsm
//   Burst-sequencing controller. A requester holds `start` high for the
//   length of a burst. The controller walks IDLE -> RUN -> DRAIN -> LAST -> IDLE
//   and gives the datapath framed busy/drain/mark strobes. It reports how many
//   RUN cycles the last completed burst had, and whether the run-length limit
//   ended it.
//
// Parameters
//   CNT_W     width of the run counter, max_len and len_out
//   HOLD_LEN  number of cycles spent in DRAIN (1..255)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   burst request, held high for the burst
//   abort      in   synchronous abort; highest priority, returns to IDLE
//   max_len    in   RUN-cycle limit, 0 = unlimited
//   busy       out  registered, next state != IDLE
//   draining   out  registered, next state is DRAIN or LAST
//   ack        out  combinational, IDLE->RUN and LAST->IDLE
//   brk        out  combinational, RUN->DRAIN
//   mark       out  registered, next state is RUN, or LAST->IDLE taken
//   len_out    out  RUN cycles of the last completed burst
//   trunc      out  last completed burst was ended by max_len
//   dbg_state  out  current FSM state (IDLE=0, RUN=1, DRAIN=2, LAST=3)
//
// Handshake: ack/brk are valid in the cycle before the state change they
// announce. They are never registered, so a consumer samples them on the same
// edge that moves the state.
module burst_seq_fsm #(
  parameter int CNT_W    = 8,
  parameter int HOLD_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] max_len,
  output logic             busy,
  output logic             draining,
  output logic             ack,
  output logic             brk,
  output logic             mark,
  output logic [CNT_W-1:0] len_out,
  output logic             trunc,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LAST  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] len_out_q, len_out_d;
  logic             trunc_q, trunc_d;
  logic             busy_q, busy_d;
  logic             draining_q, draining_d;
  logic             mark_q, mark_d;
  logic             nx_mark;
  logic             limit_hit;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    hold_cnt_d = hold_cnt_q;
    len_out_d  = len_out_q;
    trunc_d    = trunc_q;
    ack        = 1'b0;
    brk        = 1'b0;
    nx_mark    = 1'b0;
    // Only an exact match ends the run. A limit lowered below the current
    // count at runtime therefore never fires for this burst.
    limit_hit  = (max_len != '0) && (run_cnt_q == max_len);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          ack       = 1'b1;
          run_cnt_d = CNT_ONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (limit_hit || !start) begin
          // The limit wins over a simultaneous start drop, so trunc reports it.
          state_d    = DRAIN;
          brk        = 1'b1;
          len_out_d  = run_cnt_q;
          trunc_d    = limit_hit;
          hold_cnt_d = '0;
        end else if (run_cnt_q != CNT_MAX) begin
          run_cnt_d = run_cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = LAST;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      LAST: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = IDLE;
          ack     = 1'b1;
          nx_mark = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered strobes are computed from the next state. They therefore line
    // up with the state they describe rather than lagging it by a cycle.
    busy_d     = (state_d != IDLE);
    draining_d = (state_d == DRAIN) || (state_d == LAST);
    mark_d     = (state_d == RUN) || nx_mark;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      hold_cnt_q <= '0;
      len_out_q  <= '0;
      trunc_q    <= 1'b0;
      busy_q     <= 1'b0;
      draining_q <= 1'b0;
      mark_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      len_out_q  <= len_out_d;
      trunc_q    <= trunc_d;
      busy_q     <= busy_d;
      draining_q <= draining_d;
      mark_q     <= mark_d;
    end
  end

  assign busy      = busy_q;
  assign draining  = draining_q;
  assign mark      = mark_q;
  assign len_out   = len_out_q;
  assign trunc     = trunc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_burst_seq_fsm.sv
// Bench for burst_seq_fsm. Two instances are driven with the same inputs:
//   u_dut8  CNT_W=8, HOLD_LEN=2
//   u_dut3  CNT_W=3, HOLD_LEN=2, which exposes run-counter saturation
// Each instance has its own behavioural reference model. The model tracks the
// burst phase, the cycles spent in RUN, and the DRAIN cycles still to go.
module tb_burst_seq_fsm;

  localparam int HOLD = 2;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_LAST = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] max_len = 8'd0;

  logic       a_busy, a_draining, a_ack, a_brk, a_mark, a_trunc;
  logic [7:0] a_len;
  logic [1:0] a_state;
  logic       b_busy, b_draining, b_ack, b_brk, b_mark, b_trunc;
  logic [2:0] b_len;
  logic [1:0] b_state;

  burst_seq_fsm #(.CNT_W(8), .HOLD_LEN(HOLD)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_len(max_len),
    .busy(a_busy), .draining(a_draining), .ack(a_ack), .brk(a_brk),
    .mark(a_mark), .len_out(a_len), .trunc(a_trunc), .dbg_state(a_state)
  );

  burst_seq_fsm #(.CNT_W(3), .HOLD_LEN(HOLD)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_len(max_len[2:0]),
    .busy(b_busy), .draining(b_draining), .ack(b_ack), .brk(b_brk),
    .mark(b_mark), .len_out(b_len), .trunc(b_trunc), .dbg_state(b_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  typedef struct {
    int phase;
    int run_len;     // RUN cycles so far in this burst
    int drain_left;  // DRAIN cycles still to spend
    bit busy, draining, mark;
    int len;
    bit trunc;
    bit ack, brk;    // combinational outputs of the cycle that led here
  } mdl_t;

  mdl_t m[2];
  int   sat_max[2] = '{255, 7};

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{default: 0};
    r.phase = P_IDLE;
    return r;
  endfunction

  // One clock of the burst rules. The returned ack/brk belong to the current
  // cycle; every other field describes the state after the edge.
  function automatic mdl_t step(input mdl_t c, input bit s, input bit a, input int ml, input int sat);
    mdl_t n;
    bit   end_mark;
    bit   limit;
    n = c;
    n.ack = 0;
    n.brk = 0;
    end_mark = 0;
    case (c.phase)
      P_IDLE: if (s && !a) begin
        n.phase = P_RUN; n.run_len = 1; n.ack = 1;
      end
      P_RUN: begin
        limit = (ml != 0) && (c.run_len == ml);
        if (a) n.phase = P_IDLE;
        else if (limit || !s) begin
          n.phase = P_DRAIN; n.brk = 1; n.len = c.run_len; n.trunc = limit;
          n.drain_left = HOLD;
        end else n.run_len = (c.run_len < sat) ? c.run_len + 1 : sat;
      end
      P_DRAIN: begin
        if (a) n.phase = P_IDLE;
        else begin
          n.drain_left = c.drain_left - 1;
          if (n.drain_left == 0) n.phase = P_LAST;
        end
      end
      default: begin
        n.phase = P_IDLE;
        if (!a) begin n.ack = 1; end_mark = 1; end
      end
    endcase
    n.busy     = (n.phase != P_IDLE);
    n.draining = (n.phase == P_DRAIN) || (n.phase == P_LAST);
    n.mark     = (n.phase == P_RUN) || end_mark;
    return n;
  endfunction

  // Driver task: call it at a negedge. It applies the inputs, checks the
  // combinational outputs mid-cycle, clocks once, then checks the registered
  // outputs and the state.
  task automatic cycle(input bit s, input bit a, input int ml);
    mdl_t nm[2];
    start   = s;
    abort   = a;
    max_len = 8'(ml);
    #1;
    nm[0] = step(m[0], s, a, ml, sat_max[0]);
    nm[1] = step(m[1], s, a, ml % 8, sat_max[1]);
    check_eq("ack8", 32'(a_ack), 32'(nm[0].ack));
    check_eq("brk8", 32'(a_brk), 32'(nm[0].brk));
    check_eq("ack3", 32'(b_ack), 32'(nm[1].ack));
    check_eq("brk3", 32'(b_brk), 32'(nm[1].brk));
    @(posedge clk);
    #1;
    m[0] = nm[0];
    m[1] = nm[1];
    check_eq("state8", 32'(a_state), 32'(m[0].phase));
    check_eq("busy8", 32'(a_busy), 32'(m[0].busy));
    check_eq("drain8", 32'(a_draining), 32'(m[0].draining));
    check_eq("mark8", 32'(a_mark), 32'(m[0].mark));
    check_eq("len8", 32'(a_len), 32'(m[0].len));
    check_eq("trunc8", 32'(a_trunc), 32'(m[0].trunc));
    check_eq("state3", 32'(b_state), 32'(m[1].phase));
    check_eq("busy3", 32'(b_busy), 32'(m[1].busy));
    check_eq("drain3", 32'(b_draining), 32'(m[1].draining));
    check_eq("mark3", 32'(b_mark), 32'(m[1].mark));
    check_eq("len3w", 32'(b_len), 32'(m[1].len));
    check_eq("trunc3", 32'(b_trunc), 32'(m[1].trunc));
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, 32'({a_busy, b_busy}), 32'd0);
    check_eq({tag, "_draining"}, 32'({a_draining, b_draining}), 32'd0);
    check_eq({tag, "_mark"}, 32'({a_mark, b_mark}), 32'd0);
    check_eq({tag, "_len"}, 32'({a_len, b_len}), 32'd0);
    check_eq({tag, "_trunc"}, 32'({a_trunc, b_trunc}), 32'd0);
    check_eq({tag, "_state"}, 32'({a_state, b_state}), 32'd0);
    check_eq({tag, "_ackbrk"}, 32'({a_ack, a_brk, b_ack, b_brk}), 32'd0);
  endtask

  int cur_ml;

  initial begin
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic burst: start high for 3 clocks, then low
    repeat (3) cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    check_eq("basic_len", 32'(a_len), 32'd3);
    check_eq("basic_trunc", 32'(a_trunc), 32'd0);

    // limit 4 with start held for 10 cycles; a second burst starts
    repeat (10) cycle(1, 0, 4);
    check_eq("limit_len", 32'(a_len), 32'd4);
    check_eq("limit_trunc", 32'(a_trunc), 32'd1);
    check_eq("limit_rerun", 32'(a_state), P_RUN);
    repeat (6) cycle(0, 0, 4);

    // limit 2 hit in the same cycle start falls
    repeat (2) cycle(1, 0, 2);
    repeat (5) cycle(0, 0, 2);
    check_eq("tie_len", 32'(a_len), 32'd2);
    check_eq("tie_trunc", 32'(a_trunc), 32'd1);

    // abort in the first DRAIN cycle
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check_eq("abort_busy", 32'(a_busy), 32'd0);
    check_eq("abort_mark", 32'(a_mark), 32'd0);
    check_eq("abort_len", 32'(a_len), 32'd3);
    check_eq("abort_trunc", 32'(a_trunc), 32'd0);
    // abort in RUN leaves the previous burst's report alone
    repeat (4) cycle(1, 0, 0);
    cycle(1, 1, 0);
    check_eq("abort_run_len", 32'(a_len), 32'd3);
    cycle(1, 1, 0);   // abort in IDLE blocks start
    check_eq("abort_idle", 32'(a_state), P_IDLE);
    repeat (2) cycle(0, 0, 0);

    // saturation: start held 12 cycles with no limit
    repeat (12) cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    check_eq("sat_len3", 32'(b_len), 32'd7);
    check_eq("sat_trunc3", 32'(b_trunc), 32'd0);
    check_eq("sat_len8", 32'(a_len), 32'd12);

    // asynchronous reset mid-RUN
    repeat (3) cycle(1, 0, 0);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_reset_vals("midrst");
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    #1;
    check_eq("rst_ack", 32'(a_ack), 32'd1);
    cycle(1, 0, 0);
    repeat (6) cycle(0, 0, 0);

    // random traffic
    cur_ml = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) cur_ml = $urandom_range(0, 6);
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, cur_ml);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guards against any hang.
  initial begin
    #200000;
    $display("FAIL timeout reached before the end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
